// File: rtl/tri_geom_pkg.sv
// Shared types and width helpers for the triangle incenter engine.
package tri_geom_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIFF,
        S_SQRT_A,
        S_SQRT_B,
        S_SQRT_C,
        S_DIV_X,
        S_DIV_Y,
        S_DONE
    } state_t;

    function automatic int unsigned SQ_W(input int unsigned w);
        return 2 * w + 3;
    endfunction

    function automatic int unsigned LEN_W(input int unsigned w);
        return w + 2;
    endfunction

    function automatic int unsigned NUM_W(input int unsigned w);
        return 2 * w + 4;
    endfunction

    function automatic int unsigned DEN_W(input int unsigned w);
        return w + 4;
    endfunction

    function automatic int unsigned LAT(input int unsigned w);
        return 2 + 3 * (w + 2) + 2 * (2 * w + 4);
    endfunction

endpackage

// File: rtl/tri_incenter_seq_if.sv
// Point-in / geometry-out handshake bundle for tri_incenter_seq.
interface tri_incenter_seq_if #(
    parameter int unsigned W = 8
);
    import tri_geom_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic signed [W-1:0]        x1, y1, x2, y2, x3, y3;
    logic                       out_valid;
    logic                       out_ready;
    logic [LEN_W(W)-1:0]        len_a, len_b, len_c;
    logic signed [SQ_W(W)-1:0]  det2;
    logic signed [W-1:0]        inc_x, inc_y;
    logic                       degen;

    modport master (
        output in_valid, x1, y1, x2, y2, x3, y3, out_ready,
        input  in_ready, out_valid, len_a, len_b, len_c, det2, inc_x, inc_y, degen
    );

    modport slave (
        input  in_valid, x1, y1, x2, y2, x3, y3, out_ready,
        output in_ready, out_valid, len_a, len_b, len_c, det2, inc_x, inc_y, degen
    );
endinterface

// File: rtl/isqrt_seq.sv
// Iterative floor square root: one root bit per cycle, first bit resolved on the start edge.
module isqrt_seq #(
    parameter int unsigned RW = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [RW-1:0]   radicand,
    output logic            busy,
    output logic            done,
    output logic [RW/2-1:0] root
);
    localparam int unsigned HW = RW / 2;
    localparam int unsigned MW = HW + 1;
    localparam int unsigned TW = HW + 3;
    localparam int unsigned CW = $clog2(HW + 1);

    logic [MW-1:0] rem_r, src_rem, rem_n;
    logic [TW-1:0] rem_t, trial;
    logic [RW-1:0] rad_r, src_rad;
    logic [HW-1:0] src_root, root_n;
    logic [CW-1:0] left_r, left_n;
    logic          load, step;

    // Remainder stays below 2*root+1, so HW+1 bits hold it between steps.
    always_comb begin
        load     = start && !busy;
        step     = load || busy;
        src_rem  = load ? '0 : rem_r;
        src_rad  = load ? radicand : rad_r;
        src_root = load ? '0 : root;
        left_n   = load ? CW'(HW - 1) : left_r - CW'(1);
        rem_t    = {src_rem, src_rad[RW-1 -: 2]};
        trial    = TW'({src_root, 2'b01});
        if (rem_t >= trial) begin
            rem_n  = MW'(rem_t - trial);
            root_n = {src_root[HW-2:0], 1'b1};
        end else begin
            rem_n  = MW'(rem_t);
            root_n = {src_root[HW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= '0;
            rad_r  <= '0;
            root   <= '0;
            left_r <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (step) begin
                rem_r  <= rem_n;
                rad_r  <= {src_rad[RW-3:0], 2'b00};
                root   <= root_n;
                left_r <= left_n;
            end
            busy <= step && (left_n != '0);
            done <= step && (left_n == '0);
        end
    end
endmodule

// File: rtl/tri_incenter_seq.sv
// Sequential triangle engine: side lengths, doubled signed area and incenter
// using one shared square-root unit and one inline restoring divider.
module tri_incenter_seq import tri_geom_pkg::*; #(
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    tri_incenter_seq_if.slave bus
);
    localparam int unsigned VW = W + 1;
    localparam int unsigned SW = SQ_W(W);
    localparam int unsigned LW = LEN_W(W);
    localparam int unsigned NW = NUM_W(W);
    localparam int unsigned DW = DEN_W(W);
    localparam int unsigned RW = 2 * W + 4;
    localparam int unsigned CW = $clog2(NW + 1);

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;

    logic signed [W-1:0]   xa, ya, xb, yb, xc, yc;
    logic [SW-1:0]         sq_a, sq_b, sq_c;
    logic signed [SW-1:0]  det_r;
    logic [LW-1:0]         la_r, lb_r, lc_r;
    logic [DW-1:0]         den_r;
    logic signed [NW-1:0]  nx_r, ny_r;
    logic [DW-1:0]         rem_r;
    logic [NW-1:0]         q_r;
    logic signed [W-1:0]   ix_r;

    logic [LW-1:0]         o_la, o_lb, o_lc;
    logic signed [SW-1:0]  o_det;
    logic signed [W-1:0]   o_ix, o_iy;
    logic                  o_degen;

    logic                  sq_start, sq_busy, sq_done;
    logic [RW-1:0]         sq_rad;
    logic [LW-1:0]         sq_root;

    logic signed [VW-1:0]  abx, aby, acx, acy, bcx, bcy;
    logic signed [SW-1:0]  det_c;

    logic                  div_load, div_step;
    logic signed [NW-1:0]  div_num;
    logic [DW-1:0]         src_rem, rem_n;
    logic [NW-1:0]         src_q, q_n;
    logic [DW:0]           rem_t;

    function automatic logic [SW-1:0] mag2(input logic signed [VW-1:0] dx, input logic signed [VW-1:0] dy);
        logic signed [SW-1:0] ex, ey;
        ex = SW'(dx);
        ey = SW'(dy);
        return $unsigned(ex * ex + ey * ey);
    endfunction

    function automatic logic signed [NW-1:0] wsum(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                                  input logic [LW-1:0] c, input logic signed [W-1:0] p,
                                                  input logic signed [W-1:0] q, input logic signed [W-1:0] r);
        return $signed(NW'(a)) * NW'(p) + $signed(NW'(b)) * NW'(q) + $signed(NW'(c)) * NW'(r);
    endfunction

    // Sign-restore the magnitude quotient; a zero perimeter forces the origin.
    function automatic logic signed [W-1:0] quot_fix(input logic [NW-1:0] q, input logic neg, input logic zero);
        logic [NW-1:0] v;
        v = neg ? NW'(0) - q : q;
        return zero ? '0 : $signed(W'(v));
    endfunction

    isqrt_seq #(.RW(RW)) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (sq_start),
        .radicand (sq_rad),
        .busy     (sq_busy),
        .done     (sq_done),
        .root     (sq_root)
    );

    always_comb begin
        abx   = VW'(xb) - VW'(xa);
        aby   = VW'(yb) - VW'(ya);
        acx   = VW'(xc) - VW'(xa);
        acy   = VW'(yc) - VW'(ya);
        bcx   = VW'(xc) - VW'(xb);
        bcy   = VW'(yc) - VW'(yb);
        det_c = SW'(abx) * SW'(acy) - SW'(aby) * SW'(acx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sq_start = 1'b0;
        sq_rad   = '0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (bus.in_valid) state_n = S_DIFF;
            end
            S_DIFF: begin
                cnt_n   = '0;
                state_n = S_SQRT_A;
            end
            S_SQRT_A, S_SQRT_B, S_SQRT_C: begin
                sq_start = (cnt == '0) && !sq_busy;
                sq_rad   = (state == S_SQRT_A) ? RW'(sq_a) : (state == S_SQRT_B) ? RW'(sq_b) : RW'(sq_c);
                cnt_n    = cnt + CW'(1);
                if (cnt == CW'(LW - 1)) begin
                    cnt_n   = '0;
                    state_n = (state == S_SQRT_A) ? S_SQRT_B : (state == S_SQRT_B) ? S_SQRT_C : S_DIV_X;
                end
            end
            S_DIV_X: begin
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(NW)) begin
                    cnt_n   = '0;
                    state_n = S_DIV_Y;
                end
            end
            S_DIV_Y: begin
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(NW - 1)) begin
                    cnt_n   = '0;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Restoring divider step; the load cycle folds in the first quotient bit.
    always_comb begin
        div_num  = (state == S_DIV_Y) ? ny_r : nx_r;
        div_load = (state == S_DIV_X && cnt == CW'(1)) || (state == S_DIV_Y && cnt == '0);
        div_step = (state == S_DIV_X && cnt != '0) || (state == S_DIV_Y);
        src_rem  = div_load ? '0 : rem_r;
        src_q    = div_load ? (div_num[NW-1] ? $unsigned(-div_num) : $unsigned(div_num)) : q_r;
        rem_t    = {src_rem, src_q[NW-1]};
        if (rem_t >= {1'b0, den_r}) begin
            rem_n = DW'(rem_t - {1'b0, den_r});
            q_n   = {src_q[NW-2:0], 1'b1};
        end else begin
            rem_n = DW'(rem_t);
            q_n   = {src_q[NW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xa <= '0; ya <= '0; xb <= '0; yb <= '0; xc <= '0; yc <= '0;
            sq_a <= '0; sq_b <= '0; sq_c <= '0; det_r <= '0;
            la_r <= '0; lb_r <= '0; lc_r <= '0;
            den_r <= '0; nx_r <= '0; ny_r <= '0;
            rem_r <= '0; q_r <= '0; ix_r <= '0;
            o_la <= '0; o_lb <= '0; o_lc <= '0; o_det <= '0;
            o_ix <= '0; o_iy <= '0; o_degen <= 1'b0;
        end else begin
            if (state == S_IDLE && bus.in_valid) begin
                xa <= bus.x1; ya <= bus.y1;
                xb <= bus.x2; yb <= bus.y2;
                xc <= bus.x3; yc <= bus.y3;
            end
            if (state == S_DIFF) begin
                sq_a  <= mag2(bcx, bcy);
                sq_b  <= mag2(acx, acy);
                sq_c  <= mag2(abx, aby);
                det_r <= det_c;
            end
            if (sq_done && state == S_SQRT_B) la_r <= sq_root;
            if (sq_done && state == S_SQRT_C) lb_r <= sq_root;
            if (state == S_DIV_X && cnt == '0) begin
                lc_r  <= sq_root;
                den_r <= DW'(la_r) + DW'(lb_r) + DW'(sq_root);
                nx_r  <= wsum(la_r, lb_r, sq_root, xa, xb, xc);
                ny_r  <= wsum(la_r, lb_r, sq_root, ya, yb, yc);
            end
            if (div_step) begin
                rem_r <= rem_n;
                q_r   <= q_n;
            end
            if (state == S_DIV_X && cnt == CW'(NW)) ix_r <= quot_fix(q_n, nx_r[NW-1], den_r == '0);
            if (state == S_DIV_Y && cnt == CW'(NW - 1)) begin
                o_la    <= la_r;
                o_lb    <= lb_r;
                o_lc    <= lc_r;
                o_det   <= det_r;
                o_ix    <= ix_r;
                o_iy    <= quot_fix(q_n, ny_r[NW-1], den_r == '0);
                o_degen <= (det_r == '0);
            end
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.len_a     = o_la;
    assign bus.len_b     = o_lb;
    assign bus.len_c     = o_lc;
    assign bus.det2      = o_det;
    assign bus.inc_x     = o_ix;
    assign bus.inc_y     = o_iy;
    assign bus.degen     = o_degen;
endmodule

// File: tb/tb_tri_incenter_seq.sv
// Scoreboard bench for tri_incenter_seq: directed point sets with hand-derived geometry.
module tb_tri_incenter_seq;
    import tri_geom_pkg::*;

    localparam int unsigned W = 8;

    typedef struct {
        int la, lb, lc, det, ix, iy, dg;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tri_incenter_seq_if #(.W(W)) bus ();
    tri_incenter_seq #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   xfer_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: latency on each rising out_valid, field compare on each accept.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid && !prev_valid) check("latency", cyc - xfer_cyc, int'(LAT(W)));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("len_a", int'(bus.len_a), e.la);
                    check("len_b", int'(bus.len_b), e.lb);
                    check("len_c", int'(bus.len_c), e.lc);
                    check("det2", int'(bus.det2), e.det);
                    check("inc_x", int'(bus.inc_x), e.ix);
                    check("inc_y", int'(bus.inc_y), e.iy);
                    check("degen", int'(bus.degen), e.dg);
                end
            end
        end
        prev_valid = bus.out_valid;
    end

    task automatic send(input int ax, input int ay, input int bx, input int by,
                        input int cx, input int cy, input exp_t e);
        int guard = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_wait", int'(bus.in_ready), 1);
        if (!bus.in_ready) return;
        bus.x1 = W'(ax); bus.y1 = W'(ay);
        bus.x2 = W'(bx); bus.y2 = W'(by);
        bus.x3 = W'(cx); bus.y3 = W'(cy);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        xfer_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        exp_t v1, v2, v3, v4, v5;
        int   guard;
        v1 = exp_t'{11, 5, 8, 48, -1, 0, 0};
        v2 = exp_t'{5, 4, 3, 12, 1, 1, 0};
        v3 = exp_t'{360, 255, 255, 65025, -53, -53, 0};
        v4 = exp_t'{2, 4, 2, 0, 2, 0, 1};
        v5 = exp_t'{0, 0, 0, 0, 0, 0, 1};

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0; bus.x3 = '0; bus.y3 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_len_a", int'(bus.len_a), 0);
        check("rst_det2", int'(bus.det2), 0);

        send(1, -1, -4, 6, -3, -5, v1);
        drain();
        send(-128, -128, 127, -128, -128, 127, v3);
        send(0, 0, 2, 0, 4, 0, v4);
        send(3, 3, 3, 3, 3, 3, v5);
        drain();

        // Back-pressure: outputs frozen, busy pulses on in_valid ignored.
        bus.out_ready = 1'b0;
        send(0, 0, 3, 0, 0, 4, v2);
        guard = 0;
        while (!bus.out_valid && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp_out_valid", int'(bus.out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.x1 = W'(i); bus.y1 = W'(-i); bus.x2 = W'(2 * i);
            @(posedge clk); #1;
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_len_a", int'(bus.len_a), 5);
            check("bp_det2", int'(bus.det2), 12);
            check("bp_inc_x", int'(bus.inc_x), 1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("accept_in_ready", int'(bus.in_ready), 1);
        check("accept_out_valid", int'(bus.out_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        check("no_second_xfer", int'(bus.in_ready), 1);
        check("sb_empty", sb.size(), 0);

        // Reset while the second square root is in flight.
        send(1, -1, -4, 6, -3, -5, v1);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_len_a", int'(bus.len_a), 0);
        check("abort_det2", int'(bus.det2), 0);
        check("abort_inc_x", int'(bus.inc_x), 0);
        send(0, 0, 3, 0, 0, 4, v2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/tri_incenter_seq.md
# tri_incenter_seq

Sequential, parametrised triangle-geometry engine: accepts three signed 2-D points per transaction and returns the three side lengths, twice the signed area, and the incenter. It computes the incenter as (a·A + b·B + c·C)/(a+b+c). It is the clocked, width-generic successor of the combinational 8-bit side/norm/scale/add chain. It sits between the point source and downstream position logic behind valid/ready handshakes. It uses one shared iterative square-root unit and one shared iterative divider to minimise area.

## Interface
- `W`, default 8: coordinate width, signed two's complement, W ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  point set valid.
- `in_ready`  out  1  engine idle; transfer when `in_valid && in_ready`.
- `x1,y1,x2,y2,x3,y3`  in  W  point A, point B, point C (signed).
- `out_valid`  out  1  results valid; held until accepted.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `len_a,len_b,len_c`  out  W+2  floor lengths |BC|, |CA|, |AB| (unsigned).
- `det2`  out  2W+3  signed cross product (B−A)×(C−A).
- `inc_x,inc_y`  out  W  incenter (signed, truncated toward zero).
- `degen`  out  1  det2 == 0 (collinear or coincident points).

## Operation
- FSM states: IDLE → DIFF → SQRT_A → SQRT_B → SQRT_C → DIV_X → DIV_Y → DONE → IDLE.
- `in_ready` = (state == IDLE). On transfer, capture all six coordinates and go to DIFF.
- DIFF takes 1 cycle and registers the following:
  - the side vectors, W+1 bits signed;
  - the squared lengths dx²+dy², 2W+3 bits unsigned;
  - det2.
- SQRT_* states: the shared `isqrt_seq` computes a floor square root, one result bit per cycle, in W+2 cycles per side. The states run in the order a, b, c.
- After SQRT_C, register the following:
  - den = a+b+c, W+4 bits;
  - num_x = a·x1 + b·x2 + c·x3 and num_y, each 2W+4 bits signed.
- DIV_*: a restoring divider on |num|/den, one quotient bit per cycle, 2W+4 cycles each.
  - Negate the quotient if num < 0, so rounding is toward zero.
  - The result is truncated to W bits. The incenter lies inside the bounding box, so this never overflows.
- den == 0 (all points coincident): the divider is bypassed numerically, but the cycles still elapse. inc_x = inc_y = 0.
- degen is reported but never alters the computation; collinear sets still produce an incenter.
- DONE: `out_valid` = 1 and the outputs are stable. On `out_ready`, go to IDLE. The output registers retain their values until the next DONE.
- Reset (any state, including mid-SQRT/DIV): the transaction aborts. state = IDLE and all outputs = 0; `in_ready` = 1 once `rst_n` releases.

## Timing
- Latency is fixed and data-independent. L = 2 + 3(W+2) + 2(2W+4) = 7W+16 cycles, measured from the input transfer edge to the first cycle with `out_valid` = 1. W = 8 gives L = 72.
- Throughput is one transaction per L+1 cycles when `out_ready` is tied high. There is no overlap: `in_ready` = 0 from the transfer edge until the cycle after the output transfer.
- Back-pressure: with `out_ready` held low, the engine stays in DONE indefinitely and the outputs do not change.
- `in_valid` while busy is ignored; the inputs need not be held.
- All outputs are registered, so there is no combinational in→out path. `in_ready` decodes the state register only.

## Structure
- Package `tri_geom_pkg`:
  - FSM state enum;
  - width functions `SQ_W(W)=2W+3`, `LEN_W(W)=W+2`, `NUM_W(W)=2W+4`, `DEN_W(W)=W+4`;
  - latency constant function `LAT(W)`.
- Sub-module `isqrt_seq` (parameter RW = 2W+4 radicand bits):
  - start/busy/done interface;
  - floor square root in RW/2 cycles.
- The divider is small and runs inline in the top FSM.

## Test plan
- A(1,−1), B(−4,6), C(−3,−5) → len_a=11, len_b=5, len_c=8, det2=48, inc=(−1,0), degen=0, out_valid exactly 72 cycles after transfer.
- A(0,0), B(3,0), C(0,4) → lengths 5, 4, 3; det2=12; inc=(1,1); degen=0.
- Extremes W=8: A(−128,−128), B(127,−128), C(−128,127) → lengths 360, 255, 255; det2=65025; inc=(−53,−53).
- Collinear (0,0),(2,0),(4,0) → degen=1, inc=(2,0). Coincident (3,3)×3 → lengths 0, det2=0, inc=(0,0), degen=1.
- Hold `out_ready`=0 for 20 cycles while pulsing `in_valid` with new points → outputs stable, no second transfer, `in_ready`=0. Then accept → `in_ready`=1 the next cycle.
- Assert `rst_n`=0 during SQRT_B → all outputs 0 and `in_ready`=1 after release. Next transaction (second vector) → correct results at full latency.
